// File: rtl/nios2_mul_combine_if.sv
// Bus between the M-stage multiply cell and the multiply completion stage.
// The master drives M-stage products and control; the slave returns the W-stage result.
interface nios2_mul_combine_if #(
    parameter int DST_W = 5
);
    logic             M_en;
    logic             M_mul_valid;
    logic [DST_W-1:0] M_mul_dst;
    logic [31:0]      M_mul_cell_p1;
    logic [31:0]      M_mul_cell_p2;
    logic [31:0]      M_mul_cell_p3;
    logic             pipe_flush;
    logic             mul_count_clr;
    logic [31:0]      W_mul_result;
    logic [DST_W-1:0] W_mul_dst;
    logic             W_mul_valid;
    logic [31:0]      mul_count;

    modport master (
        output M_en, M_mul_valid, M_mul_dst,
        output M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3,
        output pipe_flush, mul_count_clr,
        input  W_mul_result, W_mul_dst, W_mul_valid, mul_count
    );

    modport slave (
        input  M_en, M_mul_valid, M_mul_dst,
        input  M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3,
        input  pipe_flush, mul_count_clr,
        output W_mul_result, W_mul_dst, W_mul_valid, mul_count
    );
endinterface

// File: rtl/nios2_mul_combine.sv
// Reduces three 16x16 partial products to the low 32 bits of a 32x32 product over stages A and W.
// Optional completed-multiply counter built when NIOS2_MUL_COMBINE_COUNT_EN is defined.
module nios2_mul_combine #(
    parameter int DST_W = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    nios2_mul_combine_if.slave       bus
);
    localparam int STAGES = 2;

    typedef struct packed {
        logic [DST_W-1:0] dst;
        logic [31:0]      p1;
        logic [15:0]      mid;
    } a_ent_t;

    typedef struct packed {
        logic [DST_W-1:0] dst;
        logic [31:0]      res;
    } w_ent_t;

    // vld_pipe[1] = A_valid, vld_pipe[2] = W_mul_valid
    logic [STAGES:1] vld_pipe;
    a_ent_t          a_d, a_q;
    w_ent_t          w_d, w_q;

    // Upper halves of p2/p3 only reach product bits >= 32.
    logic [31:0] unused_hi;
    assign unused_hi = {bus.M_mul_cell_p2[31:16], bus.M_mul_cell_p3[31:16]};

    always_comb begin
        a_d     = '0;
        a_d.dst = bus.M_mul_dst;
        a_d.p1  = bus.M_mul_cell_p1;
        a_d.mid = bus.M_mul_cell_p2[15:0] + bus.M_mul_cell_p3[15:0];
    end

    // Lower 16 bits of p1 pass straight through; only the upper half needs an adder.
    always_comb begin
        w_d     = '0;
        w_d.dst = a_q.dst;
        w_d.res = {a_q.p1[31:16] + a_q.mid, a_q.p1[15:0]};
    end

    always_ff @(posedge clk) begin
        if (reset)
            vld_pipe <= '0;
        else if (bus.pipe_flush)
            vld_pipe <= '0;
        else if (bus.M_en)
            vld_pipe <= {vld_pipe[STAGES-1:1], bus.M_mul_valid};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q <= '0;
            w_q <= '0;
        end else if (bus.M_en) begin
            a_q <= a_d;
            w_q <= w_d;
        end
    end

    assign bus.W_mul_result = w_q.res;
    assign bus.W_mul_dst    = w_q.dst;
    assign bus.W_mul_valid  = vld_pipe[STAGES];

`ifdef NIOS2_MUL_COMBINE_COUNT_EN
    logic [31:0] cnt_q;
    logic        cnt_inc;

    assign cnt_inc = bus.M_en & vld_pipe[1] & ~bus.pipe_flush;

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else if (bus.mul_count_clr)
            cnt_q <= '0;
        else if (cnt_inc)
            cnt_q <= cnt_q + 32'd1;
    end

    assign bus.mul_count = cnt_q;
`else
    logic unused_clr;
    assign unused_clr    = bus.mul_count_clr;
    assign bus.mul_count = '0;
`endif
endmodule

// File: tb/tb_nios2_mul_combine.sv
// Scoreboard bench for nios2_mul_combine: expected products queued at drive time, checked on W.
module tb_nios2_mul_combine;
    localparam int DST_W = 5;

    typedef struct {
        logic [31:0]      res;
        logic [DST_W-1:0] dst;
        int               age;
    } sb_ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    logic [31:0] exp_cnt = '0;
    sb_ent_t sb[$];

    nios2_mul_combine_if #(.DST_W(DST_W)) bus ();

    nios2_mul_combine #(.DST_W(DST_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of M-stage inputs from the two sources; products derive from a*b.
    task automatic step(input logic en, input logic vld, input logic [31:0] a, input logic [31:0] b,
                        input logic [DST_W-1:0] dst, input logic flush = 1'b0,
                        input logic clr = 1'b0, input logic rst = 1'b0);
        logic [31:0] prod;
        sb_ent_t     e;
        @(posedge clk);
        #2;
        prod              = a * b;
        bus.M_en          = en;
        bus.M_mul_valid   = vld;
        bus.M_mul_dst     = dst;
        bus.M_mul_cell_p1 = 32'(a[15:0]) * 32'(b[15:0]);
        bus.M_mul_cell_p2 = 32'(a[15:0]) * 32'(b[31:16]);
        bus.M_mul_cell_p3 = 32'(a[31:16]) * 32'(b[15:0]);
        bus.pipe_flush    = flush;
        bus.mul_count_clr = clr;
        reset             = rst;
        if (flush || rst)
            sb.delete();
        else if (en && vld) begin
            e.res = prod;
            e.dst = dst;
            e.age = 0;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, 32'h0, '0);
    endtask

    // Monitor: sample control at the edge, check outputs 1 time unit later.
    logic [31:0]      last_res = '0;
    logic [DST_W-1:0] last_dst = '0;
    logic             last_vld = 1'b0;

    always @(posedge clk) begin
        logic en_s, fl_s, rst_s, clr_s;
        sb_ent_t e;
        en_s  = bus.M_en;
        fl_s  = bus.pipe_flush;
        rst_s = reset;
        clr_s = bus.mul_count_clr;
        #1;
        if (rst_s) begin
            exp_cnt = '0;
            chk("rst_res", bus.W_mul_result, 32'h0);
            chk("rst_dst", 32'(bus.W_mul_dst), 32'h0);
            chk("rst_vld", 32'(bus.W_mul_valid), 32'h0);
            chk("rst_cnt", bus.mul_count, 32'h0);
        end else begin
            if (fl_s) begin
                chk("flush_vld", 32'(bus.W_mul_valid), 32'h0);
            end else if (en_s) begin
                for (int i = 0; i < sb.size(); i++) sb[i].age++;
                if (sb.size() > 0 && sb[0].age >= 2) begin
                    e = sb.pop_front();
                    chk("w_vld", 32'(bus.W_mul_valid), 32'h1);
                    chk("w_res", bus.W_mul_result, e.res);
                    chk("w_dst", 32'(bus.W_mul_dst), 32'(e.dst));
`ifdef NIOS2_MUL_COMBINE_COUNT_EN
                    exp_cnt = exp_cnt + 32'd1;
`endif
                end else begin
                    chk("no_spur", 32'(bus.W_mul_valid), 32'h0);
                end
            end else begin
                chk("stall_res", bus.W_mul_result, last_res);
                chk("stall_dst", 32'(bus.W_mul_dst), 32'(last_dst));
                chk("stall_vld", 32'(bus.W_mul_valid), 32'(last_vld));
            end
            if (clr_s) exp_cnt = '0;
            chk("cnt", bus.mul_count, exp_cnt);
        end
        last_res = bus.W_mul_result;
        last_dst = bus.W_mul_dst;
        last_vld = bus.W_mul_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.M_en = 1'b0; bus.M_mul_valid = 1'b0; bus.M_mul_dst = '0;
        bus.M_mul_cell_p1 = '0; bus.M_mul_cell_p2 = '0; bus.M_mul_cell_p3 = '0;
        bus.pipe_flush = 1'b0; bus.mul_count_clr = 1'b0;
        step(1'b1, 1'b1, 32'h1234, 32'h5678, 5'd9, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 32'h0, '0, 1'b0, 1'b0, 1'b1);

        // basic product and explicit result
        step(1'b1, 1'b1, 32'h00012345, 32'h00010002, 5'd7);
        idle(2);
        chk("basic_res", bus.W_mul_result, 32'h2347468A);
        chk("basic_dst", 32'(bus.W_mul_dst), 32'd7);
        idle(1);

        // carry drop: 0xFFFFFFFF squared
        step(1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3);
        idle(2);
        chk("wrap_res", bus.W_mul_result, 32'h00000001);
        idle(1);

        // back-to-back
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, $urandom, $urandom, 5'(i + 1));
        idle(3);

        // stall with an entry in A; junk on M must not be captured
        step(1'b1, 1'b1, 32'hDEAD0001, 32'h0BEEF123, 5'd12);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, $urandom, $urandom, 5'd30);
        idle(3);

        // flush with entries in A and W
        step(1'b1, 1'b1, 32'h11112222, 32'h33334444, 5'd1);
        step(1'b1, 1'b1, 32'h55556666, 32'h77778888, 5'd2);
        step(1'b1, 1'b1, 32'h9999AAAA, 32'hBBBBCCCC, 5'd3, 1'b1);
        idle(3);
        // flush during a stall
        step(1'b1, 1'b1, 32'h00000123, 32'h00000456, 5'd4);
        step(1'b0, 1'b0, 32'h0, 32'h0, '0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 32'h0, '0);
        idle(3);

        // counter: clear, then 5 multiplies with one flushed in A
        step(1'b1, 1'b0, 32'h0, 32'h0, '0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 32'd3, 32'd5, 5'd1);
        step(1'b1, 1'b1, 32'd7, 32'd9, 5'd2);
        idle(2);
        step(1'b1, 1'b1, 32'd11, 32'd13, 5'd3);
        step(1'b1, 1'b0, 32'h0, 32'h0, '0, 1'b1);
        step(1'b1, 1'b1, 32'd17, 32'd19, 5'd4);
        step(1'b1, 1'b1, 32'd23, 32'd29, 5'd5);
        idle(3);
`ifdef NIOS2_MUL_COMBINE_COUNT_EN
        chk("cnt_four", bus.mul_count, 32'd4);
`endif
        step(1'b1, 1'b0, 32'h0, 32'h0, '0, 1'b0, 1'b1);
        idle(1);
        chk("cnt_clr", bus.mul_count, 32'd0);

`ifdef NIOS2_MUL_COMBINE_COUNT_EN
        @(posedge clk); #2;
        force dut.cnt_q = 32'hFFFFFFFF;
        exp_cnt = 32'hFFFFFFFF;
        @(posedge clk); #2;
        release dut.cnt_q;
        step(1'b1, 1'b1, 32'd2, 32'd3, 5'd6);
        idle(3);
        chk("cnt_wrap", bus.mul_count, 32'd0);
`endif

        // random stream with random stalls
        for (int i = 0; i < 24; i++)
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 $urandom, $urandom, 5'($urandom));
        idle(3);

        // reset mid-stream
        step(1'b1, 1'b1, 32'hCAFE0001, 32'h12345678, 5'd21);
        step(1'b1, 1'b1, 32'hFACE0002, 32'h87654321, 5'd22);
        step(1'b1, 1'b1, 32'h0, 32'h0, 5'd23, 1'b0, 1'b0, 1'b1);
        idle(3);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
